// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start / DATA_W data bits (MSB first) / parity / stop.
// Presents the received data and parity bit in parallel together with the parity
// and framing check results. The frame is held until the consumer accepts it.
module parity_frame_rx #(
  parameter int DATA_W     = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_bit,
  input  logic              rx_valid,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              par_out,
  output logic              par_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shift_p0;
  logic               par_bit_p0;
  logic               frame_done;

  // Parity check: the data plus parity bit must XOR to ODD_PARITY.
  function automatic logic parity_fail(input logic [DATA_W-1:0] d, input logic p);
    return (^{d, p}) ^ ODD_PARITY;
  endfunction

  assign frame_done = rx_valid && (state == STOP);
  assign busy       = (state != IDLE);

  // Capture stage: collect data bits and the parity bit as they arrive.
  always_ff @(posedge clk) begin
    if (rx_valid && (state == DATA))
      shift_p0 <= {shift_p0[DATA_W-2:0], rx_bit};
    if (rx_valid && (state == PARITY))
      par_bit_p0 <= rx_bit;
  end

  // Framing FSM and output hold register with the accept/overrun handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      par_out   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT)
              state <= PARITY;
          end
          PARITY:  state <= STOP;
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // A completing frame takes the slot if it is empty or being freed this cycle;
      // otherwise it is dropped and the sticky overrun flag records the loss.
      if (frame_done && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        data_out  <= shift_p0;
        par_out   <= par_bit_p0;
        par_err   <= parity_fail(shift_p0, par_bit_p0);
        frame_err <= rx_bit;
      end else if (frame_done) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: directed frames followed by randomized traffic, with a
// frame-level reference model feeding a scoreboard that a separate monitor drains.
module tb_parity_frame_rx;

  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_bit = 1'b0;
  logic              rx_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid, par_out, par_err, frame_err, overrun, busy;
  logic [DATA_W-1:0] data_out;
  logic              o_valid, o_par_out, o_par_err, o_frame_err, o_overrun, o_busy;
  logic [DATA_W-1:0] o_data_out;

  parity_frame_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .reset(reset), .rx_bit(rx_bit), .rx_valid(rx_valid), .out_ready(out_ready),
    .out_valid(out_valid), .data_out(data_out), .par_out(par_out), .par_err(par_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  parity_frame_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .rx_bit(rx_bit), .rx_valid(rx_valid), .out_ready(out_ready),
    .out_valid(o_valid), .data_out(o_data_out), .par_out(o_par_out), .par_err(o_par_err),
    .frame_err(o_frame_err), .overrun(o_overrun), .busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              par;
    logic              pe_even;
    logic              pe_odd;
    logic              fe;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  exp_t got;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   gaps_on = 1'b0;
  int   rdy_mode = 0;     // 0: never ready, 1: always ready, 2: random
  bit   start_now = 1'b0; // driver is presenting a start bit with rx_valid=1
  bit   stop_now = 1'b0;  // driver is presenting a stop bit with rx_valid=1
  bit   m_valid = 1'b0;
  bit   m_ovr = 1'b0;
  bit   m_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input logic [DATA_W-1:0] d, input logic p, input logic s);
    exp_t e;
    int   ones;
    ones      = $countones(d) + (p ? 1 : 0);
    e.data    = d;
    e.par     = p;
    e.pe_even = (ones % 2) != 0;   // even parity demands an even count of ones
    e.pe_odd  = (ones % 2) == 0;   // odd parity demands an odd count of ones
    e.fe      = s;
    return e;
  endfunction

  // Reference model: frame-level bookkeeping of the single output slot.
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
      sb.delete();
    end else begin
      if (start_now) m_busy = 1'b1;
      if (stop_now) begin
        m_busy = 1'b0;
        if (!m_valid || out_ready) begin
          sb.push_back(pend);
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: per-cycle status checks, and scoreboard pop on each accepted frame.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("busy", 32'(busy), 32'(m_busy));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_empty: got out_valid=1 expected no pending frame at %0t", $time);
        end else begin
          got = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(got.data));
          chk("par_out", 32'(par_out), 32'(got.par));
          chk("par_err", 32'(par_err), 32'(got.pe_even));
          chk("frame_err", 32'(frame_err), 32'(got.fe));
          chk("odd_valid", 32'(o_valid), 32'd1);
          chk("odd_par_err", 32'(o_par_err), 32'(got.pe_odd));
        end
      end
    end
  end

  // Consumer ready generator, updated slightly after the main driver each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 plain, 1 start bit, 2 stop bit
  task automatic drive_bit(input logic b, input int kind);
    int g;
    g = gaps_on ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < g; i++) begin
      rx_valid = 1'b0;
      rx_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    rx_valid  = 1'b1;
    rx_bit    = b;
    start_now = (kind == 1);
    stop_now  = (kind == 2);
    tick();
    rx_valid  = 1'b0;
    start_now = 1'b0;
    stop_now  = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s);
    pend = make_exp(d, p, s);
    drive_bit(1'b1, 1);
    for (int i = DATA_W - 1; i >= 0; i--) drive_bit(d[i], 0);
    drive_bit(p, 0);
    drive_bit(s, 2);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_par_out", 32'(par_out), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_bit   = 1'b0;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    rdy_mode = 1;
    tick();
    apply_reset();
    mon_en = 1'b1;

    // Even parity frame, clean stop.
    send_frame(4'b1011, 1'b1, 1'b0);
    idle_cycles(3);
    // Bad parity bit, then a stop-bit framing error.
    send_frame(4'b1011, 1'b0, 1'b0);
    idle_cycles(2);
    send_frame(4'b0011, 1'b0, 1'b1);
    idle_cycles(3);

    // Consumer stalled: second frame must be dropped and overrun raised.
    rdy_mode = 0;
    tick();
    send_frame(4'b1011, 1'b1, 1'b0);
    idle_cycles(2);
    send_frame(4'b0110, 1'b0, 1'b0);
    idle_cycles(2);
    rdy_mode = 1;
    tick();
    rdy_mode = 0;
    idle_cycles(3);

    // Back-to-back frames with no idle gap.
    rdy_mode = 1;
    apply_reset();
    send_frame(4'b1100, 1'b0, 1'b0);
    send_frame(4'b0111, 1'b1, 1'b0);
    send_frame(4'b0001, 1'b0, 1'b0);
    idle_cycles(3);

    // Reset mid-frame, then a full frame delivered through rx_valid gaps.
    drive_bit(1'b1, 1);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    apply_reset();
    gaps_on = 1'b1;
    send_frame(4'b0101, 1'b0, 1'b0);
    idle_cycles(4);

    // Randomized traffic with a random consumer and occasional mid-frame resets.
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      gaps_on = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) begin
        drive_bit(1'b1, 1);
        for (int k = 0; k < int'($urandom_range(0, DATA_W)); k++)
          drive_bit(1'($urandom_range(0, 1)), 0);
        apply_reset();
      end else begin
        send_frame(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
      end
    end

    // Drain whatever is still held.
    rdy_mode = 1;
    idle_cycles(6);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
